// File: rtl/motor_nn_pkg.sv
// motor_nn_pkg: shared fixed-point widths, FSM states and width helpers for the motor NN layers
package motor_nn_pkg;
    localparam int W = 16;
    localparam int F = 9;
    localparam int PROD_W = 2 * W;
    typedef logic signed [W-1:0] fixed16_t;
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    function automatic int acc_w(input int n_in);
        return PROD_W + $clog2(n_in) + 1;
    endfunction
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/motor_dense_seq_3x3_if.sv
// motor_dense_seq_3x3_if: ap_ctrl_hs block handshake plus flattened activation/result buses
interface motor_dense_seq_3x3_if #(
    parameter int N_IN = 3,
    parameter int N_OUT = 3,
    parameter int W = motor_nn_pkg::W
);
    logic ap_start;
    logic ap_ready;
    logic ap_idle;
    logic ap_done;
    logic [W*N_IN-1:0] p_read_k;
    logic [W*N_OUT-1:0] ap_return;
    modport master (output ap_start, p_read_k, input ap_ready, ap_idle, ap_done, ap_return);
    modport slave (input ap_start, p_read_k, output ap_ready, ap_idle, ap_done, ap_return);
endinterface

// File: rtl/motor_dense_mac.sv
// motor_dense_mac: registered signed multiply-accumulate with bias-load/accumulate select
module motor_dense_mac #(
    parameter int W = motor_nn_pkg::W,
    parameter int F = motor_nn_pkg::F,
    parameter int AW = motor_nn_pkg::acc_w(3)
) (
    input logic clk,
    input logic rst,
    input logic en,
    input logic load,
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b,
    input logic signed [AW-1:0] bias,
    output logic signed [W-1:0] y_next
);
    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    assign prod = a * b;
    assign acc_next = (load ? bias : acc) + AW'(prod);
    // Truncate toward -inf and wrap: just take the W bits above the fraction
    assign y_next = acc_next[F +: W];
    always_ff @(posedge clk or posedge rst)
        if (rst) acc <= '0;
        else if (en) acc <= acc_next;
endmodule

// File: rtl/motor_dense_seq_3x3.sv
// motor_dense_seq_3x3: time-multiplexed dense layer, one shared MAC sequenced by a small FSM
module motor_dense_seq_3x3 #(
    parameter int N_IN = 3,
    parameter int N_OUT = 3,
    parameter int W = motor_nn_pkg::W,
    parameter int F = motor_nn_pkg::F,
    parameter logic [N_OUT*N_IN*W-1:0] WEIGHTS = '0,
    parameter logic [N_OUT*W-1:0] BIASES = '0
) (
    input logic ap_clk,
    input logic ap_rst,
    motor_dense_seq_3x3_if.slave bus
);
    import motor_nn_pkg::*;
    localparam int AW = acc_w(N_IN);
    localparam int IW = cnt_w(N_IN);
    localparam int JW = cnt_w(N_OUT);
    state_t state;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [W*N_IN-1:0] x;
    logic [W*N_OUT-1:0] ret;
    logic done;
    logic idle;
    logic accept;
    logic last_i;
    logic last_j;
    logic signed [W-1:0] w_cur;
    logic signed [W-1:0] x_cur;
    logic signed [W-1:0] b_cur;
    logic signed [W-1:0] y_next;
    assign w_cur = WEIGHTS[(int'(j) * N_IN + int'(i)) * W +: W];
    assign x_cur = x[int'(i) * W +: W];
    assign b_cur = BIASES[int'(j) * W +: W];
    assign last_i = i == IW'(N_IN - 1);
    assign last_j = j == JW'(N_OUT - 1);
    assign accept = state == IDLE && bus.ap_start;
    assign bus.ap_ready = accept;
    assign bus.ap_idle = idle;
    assign bus.ap_done = done;
    assign bus.ap_return = ret;
    motor_dense_mac #(.W(W), .F(F), .AW(AW)) mac (
        .clk(ap_clk),
        .rst(ap_rst),
        .en(state == MAC),
        .load(i == '0),
        .a(w_cur),
        .b(x_cur),
        .bias(AW'(b_cur) <<< F),
        .y_next(y_next)
    );
    // j outer, i inner; output j is written on its last product cycle
    always_ff @(posedge ap_clk or posedge ap_rst)
        if (ap_rst) begin
            state <= IDLE;
            i <= '0;
            j <= '0;
            x <= '0;
            ret <= '0;
            done <= 1'b0;
            idle <= 1'b1;
        end else begin
            done <= state == MAC && last_i && last_j;
            idle <= state == DONE || (state == IDLE && !bus.ap_start);
            if (accept) begin
                state <= MAC;
                x <= bus.p_read_k;
            end else if (state == MAC) begin
                if (last_i) ret[int'(j) * W +: W] <= y_next;
                i <= last_i ? '0 : i + 1'b1;
                j <= !last_i ? j : last_j ? '0 : j + 1'b1;
                if (last_i && last_j) state <= DONE;
            end else if (state == DONE) state <= IDLE;
        end
endmodule

// File: tb/tb_motor_dense_seq_3x3.sv
// tb_motor_dense_seq_3x3: five weight sets in lockstep, checked against an arithmetic reference model
module tb_motor_dense_seq_3x3;
    localparam int NI = 5;
    localparam logic [143:0] WT [NI] = '{
        {16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0200},
        {9{16'hFE00}},
        144'h1,
        {{6{16'h0000}}, {3{16'h0200}}},
        {16'h0133, 16'hFF20, 16'h0480, 16'hF9C0, 16'h0071, 16'h0200, 16'hFEFF, 16'h0311, 16'h8000}
    };
    localparam logic [47:0] BS [NI] = '{
        48'h0, {3{16'h0100}}, 48'h0, 48'h0, {16'h7FFF, 16'hF123, 16'h0055}
    };
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [47:0] xin;
    logic [NI-1:0] ready;
    logic [NI-1:0] idle;
    logic [NI-1:0] done;
    logic [47:0] ret [NI];
    logic [47:0] exp_y [NI];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < NI; g++) begin : u
        motor_dense_seq_3x3_if bus ();
        assign bus.ap_start = start;
        assign bus.p_read_k = xin;
        assign ready[g] = bus.ap_ready;
        assign idle[g] = bus.ap_idle;
        assign done[g] = bus.ap_done;
        assign ret[g] = bus.ap_return;
        motor_dense_seq_3x3 #(.WEIGHTS(WT[g]), .BIASES(BS[g])) dut (
            .ap_clk(clk),
            .ap_rst(rst),
            .bus(bus)
        );
    end
    // y_j = floor((b_j*2^9 + sum w_ji*x_i) / 2^9), wrapped to 16 bits
    function automatic logic [47:0] model(input logic [143:0] wv, input logic [47:0] bv, input logic [47:0] xv);
        logic [47:0] y;
        longint acc;
        for (int jj = 0; jj < 3; jj++) begin
            acc = longint'($signed(bv[jj*16 +: 16])) * 512;
            for (int ii = 0; ii < 3; ii++)
                acc = acc + longint'($signed(wv[(jj*3+ii)*16 +: 16])) * longint'($signed(xv[ii*16 +: 16]));
            y[jj*16 +: 16] = 16'(acc >>> 9);
        end
        return y;
    endfunction
    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Starts in an idle cycle, ends in the idle cycle after ap_done
    task automatic run(input logic [47:0] x, input bit keep);
        start = 1'b1;
        xin = x;
        #1;
        check("ready_accept", 48'(ready), 48'h1F);
        for (int k = 0; k < NI; k++) exp_y[k] = model(WT[k], BS[k], x);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) begin
                start = keep;
                xin = {$urandom, $urandom};
            end
            if (c < 10) begin
                check("done_early", 48'(done), 48'h0);
                if (c == 5) check("ready_busy", 48'(ready), 48'h0);
            end else begin
                check("done_pulse", 48'(done), 48'h1F);
                for (int k = 0; k < NI; k++) check($sformatf("ret%0d", k), ret[k], exp_y[k]);
            end
        end
        tick();
        check("idle_after", 48'(idle), 48'h1F);
        check("done_after", 48'(done), 48'h0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1'b1;
        start = 1'b0;
        xin = '0;
        repeat (3) tick();
        check("rst_idle", 48'(idle), 48'h1F);
        check("rst_done", 48'(done), 48'h0);
        for (int k = 0; k < NI; k++) check("rst_ret", ret[k], 48'h0);
        rst = 1'b0;
        tick();
        run({16'h0000, 16'h0500, 16'h0200}, 1'b0);
        check("t1_identity", ret[0], 48'h0000_0500_0200);
        run({3{16'h0200}}, 1'b0);
        check("t2_neg_bias", ret[1], 48'hFB00_FB00_FB00);
        run(48'h0001, 1'b0);
        check("t3_trunc_pos", 48'(ret[2][15:0]), 48'h0000);
        run(48'hFFFF, 1'b0);
        check("t3_trunc_neg", 48'(ret[2][15:0]), 48'hFFFF);
        run({3{16'h4000}}, 1'b0);
        check("t4_wrap", 48'(ret[3][15:0]), 48'hC000);
        for (int r = 0; r < 3; r++) run({$urandom, $urandom}, r < 2);
        start = 1'b1;
        xin = {$urandom, $urandom};
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) check("abort_ret", ret[k], 48'h0);
        check("abort_idle", 48'(idle), 48'h1F);
        check("abort_done", 48'(done), 48'h0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("abort_no_done", 48'(done), 48'h0);
        end
        for (int r = 0; r < 6; r++) run({$urandom, $urandom}, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
